// File: rtl/led_game_pkg.sv
// Shared types and helpers for the LED chaser game.
// Holds the state enum, column decode and LFSR tap mask.
package led_game_pkg;

    localparam int SCORE_W = 8;
    localparam int LEVEL_W = 4;

    // Right-shifting Fibonacci form of taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_SHOW,
        ST_DONE
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        onehot4 = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/led_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step when asked.
// Supplies the pseudo-random target column for each round.
module led_lfsr16
    import led_game_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= seed;
        end else if (step) begin
            value <= {^(value & LFSR_TAPS), value[15:1]};
        end
    end

endmodule

// File: rtl/led_round_scheduler.sv
// Round sequencer for the LED chaser game: paces rounds,
// opens a shrinking response window and keeps the score.
module led_round_scheduler
    import led_game_pkg::*;
#(
    parameter int unsigned GAP_TICKS    = 2_500_000,
    parameter int unsigned TIMEOUT_BASE = 25_000_000,
    parameter int unsigned TIMEOUT_STEP = 2_500_000,
    parameter int unsigned TIMEOUT_MIN  = 5_000_000,
    parameter int unsigned ROUNDS       = 16,
    parameter int unsigned LIVES        = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_game,
    input  logic [3:0]         button,
    output logic [3:0]         led,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives_left,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               game_over,
    output logic               game_won
);

    localparam logic [32:0] DEC_LIM =
        33'(TIMEOUT_STEP) + 33'(TIMEOUT_MIN);

    state_t      state;
    logic [31:0] gap_cnt;
    logic [31:0] timer;
    logic [31:0] window;
    logic [31:0] next_window;
    logic [1:0]  hit_cnt;
    logic [3:0]  button_q;
    logic        start_q;
    logic [15:0] lfsr;
    logic        lfsr_unused;

    logic        start_edge;
    logic [3:0]  press;
    logic [3:0]  target_oh;
    logic        hit;
    logic        miss;
    logic        last_hit;
    logic        last_life;
    logic        enter_gap;

    assign lfsr_unused = ^lfsr[15:2];

    always_comb begin
        start_edge = start_game & ~start_q;
        press      = button & ~button_q;
        target_oh  = onehot4(lfsr[1:0]);
        hit        = 1'b0;
        miss       = 1'b0;
        if (state == ST_SHOW) begin
            hit = (press == target_oh);
            // A press on the final window cycle is judged, not timed out
            if (press != 4'b0000) begin
                miss = (press != target_oh);
            end else begin
                miss = (timer == window - 32'd1);
            end
        end
        last_hit  = (score == SCORE_W'(ROUNDS - 1));
        last_life = (lives_left == 2'd1);
        enter_gap = (hit && !last_hit) || (miss && !last_life);
        if ((state == ST_IDLE || state == ST_DONE) && start_edge) begin
            enter_gap = 1'b1;
        end
        if ({1'b0, window} >= DEC_LIM) begin
            next_window = window - TIMEOUT_STEP;
        end else begin
            next_window = TIMEOUT_MIN;
        end
    end

    led_lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (enter_gap),
        .seed    (LFSR_SEED),
        .value   (lfsr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            timer      <= '0;
            window     <= '0;
            hit_cnt    <= '0;
            button_q   <= '0;
            start_q    <= 1'b0;
            led        <= '0;
            score      <= '0;
            lives_left <= '0;
            level      <= '0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            game_won   <= 1'b0;
        end else begin
            button_q <= button;
            start_q  <= start_game;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_edge) begin
                        score      <= '0;
                        lives_left <= 2'(LIVES);
                        level      <= '0;
                        hit_cnt    <= '0;
                        window     <= TIMEOUT_BASE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_TICKS - 32'd1) begin
                        state <= ST_SHOW;
                        timer <= '0;
                        led   <= target_oh;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                ST_SHOW: begin
                    if (hit) begin
                        if (score != '1) begin
                            score <= score + 1'b1;
                        end
                        if (last_hit) begin
                            state     <= ST_DONE;
                            led       <= 4'b1111;
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                            game_won  <= 1'b1;
                        end else begin
                            hit_cnt <= hit_cnt + 2'd1;
                            if (hit_cnt == 2'd3) begin
                                window <= next_window;
                                if (level != '1) begin
                                    level <= level + 1'b1;
                                end
                            end
                        end
                    end else if (miss) begin
                        lives_left <= lives_left - 2'd1;
                        if (last_life) begin
                            state     <= ST_DONE;
                            led       <= 4'b0000;
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                            game_won  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
            endcase
            if (enter_gap) begin
                state     <= ST_GAP;
                gap_cnt   <= '0;
                led       <= 4'b0000;
                busy      <= 1'b1;
                game_over <= 1'b0;
                game_won  <= 1'b0;
            end
        end
    end

endmodule
